pipe_stage_reg: RTL

//  Parametrised inter-stage pipeline register; replaces the per-stage hand-written buffers (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_stage_reg_pkg.sv | 48 ++++
 rtl/pipe_stage_reg_if.sv | 28 ++
 rtl/pipe_stage_reg_sat_counter.sv | 42 ++++
 rtl/pipe_stage_reg.sv | 90 +++++++++
 4 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the inter-stage pipeline register: stall bit indices,
// reset polarity, per-stage NOP payloads and the one-hot mode encoding.
package pipe_stage_reg_pkg;

  // Reset level that clears state.
  localparam logic RST_ENABLE  = 1'b0;
  localparam logic RST_DISABLE = 1'b1;

  // Stall vector bit assignment used by the stall controller.
  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;
  localparam int STALL_W_DEFAULT = 6;

  // Payload loaded into each inter-stage register on reset, flush or bubble.
  localparam logic [31:0] IF_ID_NOP_PAYLOAD  = 32'h0000_0000;
  localparam logic [31:0] ID_EX_NOP_PAYLOAD  = 32'h0000_0000;
  localparam logic [31:0] EX_MEM_NOP_PAYLOAD = 32'h0000_0000;
  localparam logic [31:0] MEM_WB_NOP_PAYLOAD = 32'h0000_0000;

  // One-hot register update modes.
  typedef enum logic [2:0] {
    MODE_ADV = 3'b001,
    MODE_BUB = 3'b010,
    MODE_HLD = 3'b100
  } mode_e;

  // Stall bit that gates the register sitting after stage n.
  function automatic int stall_bit(input int n);
    return n;
  endfunction

  // Stall bit of the stage that consumes this register's output.
  function automatic int stall_bit_next(input int n);
    return n + 1;
  endfunction

  // Priority decode: upstream running wins even if downstream claims a stall.
  function automatic mode_e decode_mode(input logic up_stall, input logic dn_stall);
    if (!up_stall)     return MODE_ADV;
    else if (!dn_stall) return MODE_BUB;
    else               return MODE_HLD;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle between the stall controller / upstream stage and one
// inter-stage register.
interface pipe_stage_reg_if #(
  parameter int DATA_W  = 32,
  parameter int STALL_W = 6,
  parameter int CNT_W   = 4
);

  logic [STALL_W-1:0] stall;
  logic               flush;
  logic [DATA_W-1:0]  in_data;
  logic               in_valid;
  logic [DATA_W-1:0]  out_data;
  logic               out_valid;
  logic [CNT_W-1:0]   hold_cnt;
  logic               hold_sat;

  modport master (
    output stall, flush, in_data, in_valid,
    input  out_data, out_valid, hold_cnt, hold_sat
  );

  modport slave (
    input  stall, flush, in_data, in_valid,
    output out_data, out_valid, hold_cnt, hold_sat
  );

endinterface

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; sat is registered together
// with cnt so both always describe the same value.
module sat_counter
  import pipe_stage_reg_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_nxt;

  // NOTE: give every always_comb output a default first so no path leaves it
  // unassigned and infers a latch.
  always_comb begin
    cnt_nxt = cnt;
    if (clr)
      cnt_nxt = '0;
    else if (inc && (cnt != CNT_MAX))
      cnt_nxt = cnt + 1'b1;
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      cnt <= '0;
      sat <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      sat <= (cnt_nxt == CNT_MAX);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register with flush, valid bit and a
// saturating count of consecutive hold cycles.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] NOP_VALUE = '0,
  parameter int                STALL_W   = STALL_W_DEFAULT,
  parameter int                STAGE     = STALL_ID,
  parameter int                CNT_W     = 4
) (
  input logic            clk,
  input logic            rst,
  pipe_stage_reg_if.slave bus
);

  localparam int UP_BIT = stall_bit(STAGE);
  localparam int DN_BIT = stall_bit_next(STAGE);

  if ((STAGE < 0) || (DN_BIT >= STALL_W)) begin : g_bad_stage
    $error("pipe_stage_reg: STAGE=%0d needs STAGE+1 < STALL_W=%0d", STAGE, STALL_W);
  end
  if (DATA_W < 1) begin : g_bad_width
    $error("pipe_stage_reg: DATA_W=%0d must be at least 1", DATA_W);
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("pipe_stage_reg: CNT_W=%0d must be at least 1", CNT_W);
  end

  mode_e             mode;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              cnt_clr;
  logic              cnt_inc;

  // Only two bits of the shared stall vector concern this instance.
  logic unused_stall_bits;
  assign unused_stall_bits = ^bus.stall;

  always_comb begin
    mode = decode_mode(bus.stall[UP_BIT], bus.stall[DN_BIT]);
  end

  // Payload and valid: reset and flush both load the bubble values. The
  // payload is reset too so a resuming stage never sees stale data.
  always_ff @(posedge clk) begin
    if ((rst == RST_ENABLE) || bus.flush) begin
      data_q  <= NOP_VALUE;
      valid_q <= 1'b0;
    end else begin
      unique case (mode)
        MODE_ADV: begin
          data_q  <= bus.in_data;
          valid_q <= bus.in_valid;
        end
        MODE_BUB: begin
          data_q  <= NOP_VALUE;
          valid_q <= 1'b0;
        end
        MODE_HLD: begin
          data_q  <= data_q;
          valid_q <= valid_q;
        end
        default: begin
          data_q  <= NOP_VALUE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  // The hold run restarts on anything other than an unflushed hold.
  assign cnt_inc = (mode == MODE_HLD);
  assign cnt_clr = bus.flush || !cnt_inc;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_hold_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (cnt_inc),
    .cnt (bus.hold_cnt),
    .sat (bus.hold_sat)
  );

  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;

endmodule
